// File: rtl/noc_flit_reader.sv
// Read-side flit consumer: pops the clock-crossing FIFO, routes packets in XY order and
// presents flits to the crossbar through a registered valid/ready stage.
module noc_flit_reader #(
    parameter int unsigned FLIT_W  = 32,
    parameter int unsigned COORD_W = 4,
    parameter int unsigned LOCAL_X = 0,
    parameter int unsigned LOCAL_Y = 0
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic [FLIT_W-1:0] rdata,
    input  logic              rempty,
    output logic              rinc,
    output logic [FLIT_W-1:0] out_flit,
    output logic [4:0]        out_port,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err_drop,
    output logic [7:0]        drop_cnt,
    output logic [15:0]       pkt_cnt
);

    localparam logic [1:0] TypeHead = 2'b01;
    localparam logic [1:0] TypeTail = 2'b10;

    localparam logic [4:0] PortL = 5'b00001;
    localparam logic [4:0] PortN = 5'b00010;
    localparam logic [4:0] PortE = 5'b00100;
    localparam logic [4:0] PortS = 5'b01000;
    localparam logic [4:0] PortW = 5'b10000;

    localparam logic [COORD_W-1:0] LocalX = COORD_W'(LOCAL_X);
    localparam logic [COORD_W-1:0] LocalY = COORD_W'(LOCAL_Y);

    typedef enum logic {StIdle, StPkt} state_e;

    state_e              state_q, state_d;
    logic [4:0]          route_q, route_d;
    logic [FLIT_W-1:0]   out_flit_q, out_flit_d;
    logic [4:0]          out_port_q, out_port_d;
    logic                out_valid_q, out_valid_d;
    logic                err_drop_q, err_drop_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic [15:0]         pkt_cnt_q, pkt_cnt_d;

    logic [1:0]          flit_type;
    logic [COORD_W-1:0]  dest_x;
    logic [COORD_W-1:0]  dest_y;
    logic [4:0]          head_port;
    logic                is_head;
    logic                discard;
    logic                can_load;
    logic                fwd_pop;
    logic                accept;

    assign flit_type = rdata[FLIT_W-1:FLIT_W-2];
    assign dest_x    = rdata[FLIT_W-3 -: COORD_W];
    assign dest_y    = rdata[FLIT_W-3-COORD_W -: COORD_W];
    // HEAD (01) and SINGLE (11) both carry destination coordinates.
    assign is_head   = flit_type[0];

    always_comb begin
        head_port = PortL;
        if (dest_x > LocalX) begin
            head_port = PortE;
        end else if (dest_x < LocalX) begin
            head_port = PortW;
        end else if (dest_y > LocalY) begin
            head_port = PortN;
        end else if (dest_y < LocalY) begin
            head_port = PortS;
        end
    end

    // Body/tail with no open packet is thrown away regardless of crossbar backpressure.
    assign discard  = (state_q == StIdle) && !is_head;
    assign can_load = !out_valid_q || out_ready;
    assign fwd_pop  = !rempty && !discard && can_load;
    assign accept   = out_valid_q && out_ready;
    assign rinc     = !rrst && !rempty && (discard || can_load);

    always_comb begin
        state_d     = state_q;
        route_d     = route_q;
        out_flit_d  = out_flit_q;
        out_port_d  = out_port_q;
        out_valid_d = out_valid_q;
        err_drop_d  = 1'b0;
        drop_cnt_d  = drop_cnt_q;
        pkt_cnt_d   = pkt_cnt_q;

        if (accept) begin
            out_valid_d = 1'b0;
            // Forwarded flits with the top type bit set are TAIL or SINGLE: packet complete.
            if (out_flit_q[FLIT_W-1]) begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
        end

        if (!rempty && discard) begin
            err_drop_d = 1'b1;
        end else if (fwd_pop) begin
            out_flit_d  = rdata;
            out_valid_d = 1'b1;
            if (is_head) begin
                out_port_d = head_port;
                route_d    = head_port;
                state_d    = (flit_type == TypeHead) ? StPkt : StIdle;
                err_drop_d = (state_q == StPkt);
            end else begin
                out_port_d = route_q;
                if (flit_type == TypeTail) begin
                    state_d = StIdle;
                end
            end
        end

        if (err_drop_d && (drop_cnt_q != 8'hff)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q     <= StIdle;
            route_q     <= '0;
            out_flit_q  <= '0;
            out_port_q  <= '0;
            out_valid_q <= 1'b0;
            err_drop_q  <= 1'b0;
            drop_cnt_q  <= '0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            route_q     <= route_d;
            out_flit_q  <= out_flit_d;
            out_port_q  <= out_port_d;
            out_valid_q <= out_valid_d;
            err_drop_q  <= err_drop_d;
            drop_cnt_q  <= drop_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign out_flit  = out_flit_q;
    assign out_port  = out_port_q;
    assign out_valid = out_valid_q;
    assign err_drop  = err_drop_q;
    assign drop_cnt  = drop_cnt_q;
    assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_noc_flit_reader.sv
// Bench for noc_flit_reader at LOCAL=(2,2): directed scenarios plus a random flit stream
// checked against a packet-level model.
module tb_noc_flit_reader;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;
    localparam int unsigned LX = 2;
    localparam int unsigned LY = 2;

    logic        rclk = 1'b0;
    logic        rrst = 1'b1;
    logic [31:0] rdata;
    logic        rempty;
    logic        rinc;
    logic [31:0] out_flit;
    logic [4:0]  out_port;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        err_drop;
    logic [7:0]  drop_cnt;
    logic [15:0] pkt_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state and expectations
    int          e_drop = 0;
    int          e_pkt  = 0;
    bit          m_in_pkt = 1'b0;
    logic [4:0]  m_route = 5'b0;
    int          m_drops = 0;
    logic [31:0] exp_flit[$];
    logic [4:0]  exp_port[$];

    // Fall-through FIFO model
    logic [31:0] mem [256];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;
    assign rempty = (wr_ptr == rd_ptr);
    assign rdata  = mem[rd_ptr];
    always @(posedge rclk) if (rinc) rd_ptr <= rd_ptr + 8'd1;

    always #5 rclk = ~rclk;

    noc_flit_reader #(
        .FLIT_W (32),
        .COORD_W(4),
        .LOCAL_X(LX),
        .LOCAL_Y(LY)
    ) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .rdata    (rdata),
        .rempty   (rempty),
        .rinc     (rinc),
        .out_flit (out_flit),
        .out_port (out_port),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err_drop (err_drop),
        .drop_cnt (drop_cnt),
        .pkt_cnt  (pkt_cnt)
    );

    task automatic push(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    function automatic logic [31:0] mk(input logic [1:0] t, input int unsigned x,
                                       input int unsigned y);
        return {t, 4'(x), 4'(y), 22'($urandom)};
    endfunction

    function automatic logic [4:0] xy_port(input logic [31:0] f);
        int unsigned dx = f[29:26];
        int unsigned dy = f[25:22];
        if (dx > LX) return 5'b00100;
        if (dx < LX) return 5'b10000;
        if (dy > LY) return 5'b00010;
        if (dy < LY) return 5'b01000;
        return 5'b00001;
    endfunction

    // Packet-level behaviour: what happens to each flit, in arrival order.
    task automatic model_flit(input logic [31:0] f);
        logic [1:0] t = f[31:30];
        if (!m_in_pkt && (t == T_BODY || t == T_TAIL)) begin
            m_drops++;
            e_drop = (e_drop < 255) ? e_drop + 1 : 255;
        end else begin
            if (t == T_HEAD || t == T_SINGLE) begin
                if (m_in_pkt) begin
                    m_drops++;
                    e_drop = (e_drop < 255) ? e_drop + 1 : 255;
                end
                m_route  = xy_port(f);
                m_in_pkt = (t == T_HEAD);
            end else if (t == T_TAIL) begin
                m_in_pkt = 1'b0;
            end
            exp_flit.push_back(f);
            exp_port.push_back(m_route);
            if (t[1]) e_pkt = (e_pkt + 1) % 65536;
        end
    endtask

    task automatic drain();
        int cyc = 0;
        out_ready = 1'b1;
        while (!(rempty && !out_valid) && cyc < 200) begin
            @(posedge rclk); #1;
            cyc++;
        end
        if (!(rempty && !out_valid)) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: rempty=%b out_valid=%b, want drained", rempty, out_valid);
        end
    endtask

    task automatic test_reset();
        rrst = 1'b1;
        repeat (2) @(posedge rclk);
        #1;
        n_vec++;
        if ({out_valid, out_flit, out_port, err_drop, drop_cnt, pkt_cnt, rinc} !== '0) begin
            n_err++;
            $display("FAIL reset_state: valid=%b flit=%h port=%b err=%b drop=%0d pkt=%0d rinc=%b, want all 0",
                     out_valid, out_flit, out_port, err_drop, drop_cnt, pkt_cnt, rinc);
        end
        rrst = 1'b0;
    endtask

    task automatic test_single();
        logic [31:0] f = mk(T_SINGLE, 3, 0);
        out_ready = 1'b1;
        @(posedge rclk); #1;
        push(f);
        #1;
        n_vec++;
        if (rinc !== 1'b1) begin n_err++; $display("FAIL single_rinc: got %b want 1", rinc); end
        @(posedge rclk); #1;
        n_vec++;
        if (rinc !== 1'b0 || out_valid !== 1'b1 || out_port !== 5'b00100 || out_flit !== f) begin
            n_err++;
            $display("FAIL single_out: rinc=%b valid=%b port=%b flit=%h, want 0 1 00100 %h",
                     rinc, out_valid, out_port, out_flit, f);
        end
        @(posedge rclk); #1;
        e_pkt++;
        n_vec++;
        if (out_valid !== 1'b0 || pkt_cnt !== 16'(e_pkt)) begin
            n_err++;
            $display("FAIL single_pkt: valid=%b pkt=%0d, want 0 %0d", out_valid, pkt_cnt, e_pkt);
        end
    endtask

    task automatic test_packet();
        logic [31:0] pk [5];
        pk[0] = mk(T_HEAD, 2, 1);
        for (int i = 1; i < 4; i++) pk[i] = mk(T_BODY, $urandom_range(0, 15), 0);
        pk[4] = mk(T_TAIL, 0, 0);
        out_ready = 1'b1;
        @(posedge rclk); #1;
        for (int i = 0; i < 5; i++) push(pk[i]);
        for (int i = 0; i < 5; i++) begin
            @(posedge rclk); #1;
            n_vec++;
            if (out_valid !== 1'b1 || out_port !== 5'b01000 || out_flit !== pk[i]) begin
                n_err++;
                $display("FAIL pkt_flit[%0d]: valid=%b port=%b flit=%h, want 1 01000 %h",
                         i, out_valid, out_port, out_flit, pk[i]);
            end
        end
        @(posedge rclk); #1;
        e_pkt++;
        n_vec++;
        if (out_valid !== 1'b0 || pkt_cnt !== 16'(e_pkt)) begin
            n_err++;
            $display("FAIL pkt_done: valid=%b pkt=%0d, want 0 %0d", out_valid, pkt_cnt, e_pkt);
        end
        // Back in IDLE, a stray body must be dropped.
        push(mk(T_BODY, 1, 1));
        @(posedge rclk); #1;
        e_drop++;
        n_vec++;
        if (err_drop !== 1'b1 || drop_cnt !== 8'(e_drop) || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL pkt_idle_drop: err=%b drop=%0d valid=%b, want 1 %0d 0",
                     err_drop, drop_cnt, out_valid, e_drop);
        end
    endtask

    task automatic test_stall();
        logic [31:0] pk [5];
        logic [31:0] prev_flit = '0;
        logic [4:0]  prev_port = '0;
        bit          prev_stall = 1'b0;
        bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int          idx = 0;
        pk[0] = mk(T_HEAD, 2, 1);
        for (int i = 1; i < 4; i++) pk[i] = mk(T_BODY, i, i);
        pk[4] = mk(T_TAIL, 0, 0);
        @(posedge rclk); #1;
        for (int i = 0; i < 5; i++) push(pk[i]);
        for (int cyc = 0; cyc < 60 && idx < 5; cyc++) begin
            @(posedge rclk); #1;
            out_ready = pat[cyc % 4];
            @(negedge rclk);
            if (prev_stall) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_flit !== prev_flit || out_port !== prev_port) begin
                    n_err++;
                    $display("FAIL stall_hold: valid=%b flit=%h port=%b, want 1 %h %b",
                             out_valid, out_flit, out_port, prev_flit, prev_port);
                end
            end
            if (out_valid && !out_ready) begin
                n_vec++;
                if (rinc !== 1'b0) begin n_err++; $display("FAIL stall_rinc: got %b want 0", rinc); end
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (out_flit !== pk[idx] || out_port !== 5'b01000) begin
                    n_err++;
                    $display("FAIL stall_order[%0d]: flit=%h port=%b, want %h 01000",
                             idx, out_flit, out_port, pk[idx]);
                end
                idx++;
            end
            prev_stall = out_valid && !out_ready;
            prev_flit  = out_flit;
            prev_port  = out_port;
        end
        drain();
        e_pkt++;
        n_vec++;
        if (idx != 5 || pkt_cnt !== 16'(e_pkt)) begin
            n_err++;
            $display("FAIL stall_count: accepted=%0d pkt=%0d, want 5 %0d", idx, pkt_cnt, e_pkt);
        end
    endtask

    task automatic test_discard();
        out_ready = 1'b0;
        @(posedge rclk); #1;
        push(mk(T_BODY, 1, 1));
        push(mk(T_TAIL, 3, 3));
        #1;
        n_vec++;
        if (rinc !== 1'b1) begin n_err++; $display("FAIL discard_rinc0: got %b want 1", rinc); end
        @(posedge rclk); #1;
        n_vec++;
        if (err_drop !== 1'b1 || out_valid !== 1'b0 || rinc !== 1'b1) begin
            n_err++;
            $display("FAIL discard_first: err=%b valid=%b rinc=%b, want 1 0 1", err_drop, out_valid, rinc);
        end
        @(posedge rclk); #1;
        e_drop += 2;
        n_vec++;
        if (err_drop !== 1'b1 || out_valid !== 1'b0 || rinc !== 1'b0 || drop_cnt !== 8'(e_drop)) begin
            n_err++;
            $display("FAIL discard_second: err=%b valid=%b rinc=%b drop=%0d, want 1 0 0 %0d",
                     err_drop, out_valid, rinc, drop_cnt, e_drop);
        end
        @(posedge rclk); #1;
        n_vec++;
        if (err_drop !== 1'b0) begin n_err++; $display("FAIL discard_pulse_end: got %b want 0", err_drop); end
    endtask

    task automatic test_missing_tail();
        logic [31:0] h1 = mk(T_HEAD, 2, 2);
        logic [31:0] h2 = mk(T_HEAD, 0, 5);
        logic [31:0] b  = mk(T_BODY, 9, 9);
        out_ready = 1'b1;
        @(posedge rclk); #1;
        push(h1); push(h2); push(b); push(mk(T_TAIL, 0, 0));
        @(posedge rclk); #1;
        n_vec++;
        if (out_flit !== h1 || out_port !== 5'b00001 || err_drop !== 1'b0) begin
            n_err++;
            $display("FAIL mt_first: flit=%h port=%b err=%b, want %h 00001 0", out_flit, out_port, err_drop, h1);
        end
        @(posedge rclk); #1;
        e_drop++;
        n_vec++;
        if (out_flit !== h2 || out_port !== 5'b10000 || err_drop !== 1'b1 || drop_cnt !== 8'(e_drop)) begin
            n_err++;
            $display("FAIL mt_second: flit=%h port=%b err=%b drop=%0d, want %h 10000 1 %0d",
                     out_flit, out_port, err_drop, drop_cnt, h2, e_drop);
        end
        @(posedge rclk); #1;
        n_vec++;
        if (out_valid !== 1'b1 || out_flit !== b || out_port !== 5'b10000 || err_drop !== 1'b0) begin
            n_err++;
            $display("FAIL mt_body_in_pkt: valid=%b flit=%h port=%b err=%b, want 1 %h 10000 0",
                     out_valid, out_flit, out_port, err_drop, b);
        end
        drain();
        e_pkt++;
        n_vec++;
        if (pkt_cnt !== 16'(e_pkt) || drop_cnt !== 8'(e_drop)) begin
            n_err++;
            $display("FAIL mt_counts: pkt=%0d drop=%0d, want %0d %0d", pkt_cnt, drop_cnt, e_pkt, e_drop);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        @(posedge rclk); #1;
        push(mk(T_HEAD, 4, 4)); push(mk(T_BODY, 1, 1)); push(mk(T_BODY, 2, 2));
        repeat (3) @(posedge rclk);
        #1;
        rrst = 1'b1;
        #1;
        n_vec++;
        if ({out_valid, out_flit, out_port, err_drop, drop_cnt, pkt_cnt, rinc} !== '0) begin
            n_err++;
            $display("FAIL rst_mid: valid=%b flit=%h port=%b err=%b drop=%0d pkt=%0d rinc=%b, want all 0",
                     out_valid, out_flit, out_port, err_drop, drop_cnt, pkt_cnt, rinc);
        end
        push(mk(T_BODY, 3, 3));
        #1;
        n_vec++;
        if (rinc !== 1'b0) begin n_err++; $display("FAIL rst_rinc_gated: got %b want 0", rinc); end
        @(posedge rclk); #1;
        rrst = 1'b0;
        e_drop = 0; e_pkt = 0; m_in_pkt = 1'b0;
        @(posedge rclk); #1;
        e_drop = 1;
        n_vec++;
        if (err_drop !== 1'b1 || drop_cnt !== 8'd1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_then_drop: err=%b drop=%0d valid=%b, want 1 1 0", err_drop, drop_cnt, out_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] pend[$];
        logic [31:0] prev_flit = '0;
        logic [4:0]  prev_port = '0;
        bit          prev_stall = 1'b0;
        int          pulses = 0;
        int          cyc = 0;
        m_drops = 0;
        exp_flit.delete();
        exp_port.delete();
        for (int i = 0; i < 150; i++) begin
            int unsigned r = $urandom_range(0, 9);
            logic [1:0] t = (r < 2) ? T_HEAD : (r < 7) ? T_BODY : (r < 9) ? T_TAIL : T_SINGLE;
            logic [31:0] f = mk(t, $urandom_range(0, 4), $urandom_range(0, 4));
            pend.push_back(f);
            model_flit(f);
        end
        begin
            logic [31:0] f = mk(T_TAIL, 0, 0);
            pend.push_back(f);
            model_flit(f);
        end
        while (!(pend.size() == 0 && rempty && !out_valid) && cyc < 4000) begin
            @(posedge rclk); #1;
            cyc++;
            out_ready = ($urandom_range(0, 9) < 7);
            if (pend.size() > 0 && $urandom_range(0, 3) != 0) push(pend.pop_front());
            @(negedge rclk);
            if (err_drop) pulses++;
            if (prev_stall) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_flit !== prev_flit || out_port !== prev_port) begin
                    n_err++;
                    $display("FAIL rnd_hold: valid=%b flit=%h port=%b, want 1 %h %b",
                             out_valid, out_flit, out_port, prev_flit, prev_port);
                end
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_flit.size() == 0) begin
                    n_err++;
                    $display("FAIL rnd_extra: flit=%h port=%b, want no flit", out_flit, out_port);
                end else begin
                    logic [31:0] ef = exp_flit.pop_front();
                    logic [4:0]  ep = exp_port.pop_front();
                    if (out_flit !== ef || out_port !== ep) begin
                        n_err++;
                        $display("FAIL rnd_flit: flit=%h port=%b, want %h %b", out_flit, out_port, ef, ep);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_flit  = out_flit;
            prev_port  = out_port;
        end
        n_vec++;
        if (pend.size() != 0 || !rempty || out_valid || exp_flit.size() != 0) begin
            n_err++;
            $display("FAIL rnd_complete: pending=%0d missing=%0d valid=%b, want 0 0 0",
                     pend.size(), exp_flit.size(), out_valid);
        end
        n_vec++;
        if (drop_cnt !== 8'(e_drop) || pkt_cnt !== 16'(e_pkt) || pulses != m_drops) begin
            n_err++;
            $display("FAIL rnd_counts: drop=%0d pkt=%0d pulses=%0d, want %0d %0d %0d",
                     drop_cnt, pkt_cnt, pulses, e_drop, e_pkt, m_drops);
        end
    endtask

    task automatic test_drop_saturate();
        out_ready = 1'b0;
        for (int r = 0; r < 5; r++) begin
            @(posedge rclk); #1;
            for (int i = 0; i < 60; i++) push(mk(T_BODY, i % 5, 0));
            repeat (62) @(posedge rclk);
            #1;
        end
        n_vec++;
        if (drop_cnt !== 8'd255 || out_valid !== 1'b0 || !rempty) begin
            n_err++;
            $display("FAIL drop_saturate: drop=%0d valid=%b rempty=%b, want 255 0 1",
                     drop_cnt, out_valid, rempty);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_packet();
        test_stall();
        drain();
        test_discard();
        test_missing_tail();
        test_reset_mid();
        test_random();
        test_drop_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
